mem_arbiter: RTL and testbench

- Shares the single synchronous-read memory port between the CPU's instruction-fetch requester and its load/store requester.
- Grants at most one request per cycle and routes the 1-cycle-latency read data back to the requester that owns it.
- Flags any address beyond the memory size as an error instead of issuing it.
- Sits between the SOC state machine and the Memory block, replacing the direct PC/rs1+imm address mux.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arb_grant.sv | 48 ++++
 rtl/mem_arbiter.sv | 70 +++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
// Owner encoding tags the access whose response arrives next cycle.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  function automatic logic [31:0] mem_words(input int unsigned size_kb);
    return 32'(size_kb) * 32'd256;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wmask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_wmask, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_wmask, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision between instruction and data requesters: fixed priority with
// a starvation guard, or round robin, plus the bookkeeping both need.
module mem_arb_grant #(
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic       last_d;
  logic       i_wins;

  always_comb begin
    i_wins = i_req;
    if (i_req && d_req) begin
      if (RR_MODE != 0) i_wins = last_d;
      else              i_wins = (starve_cnt == LIMIT);
    end
  end

  assign i_gnt = i_wins;
  assign d_gnt = d_req && !i_wins;

  // Pointer resets as if data had the last grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= 8'd0;
      last_d     <= 1'b1;
    end else begin
      if (i_req && !i_gnt) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= 8'd0;
      end
      if (d_gnt)      last_d <= 1'b1;
      else if (i_gnt) last_d <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and
// load/store, routing the 1-cycle-latency response back to its owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEMORY_SIZE_KB = 8,
  parameter int RR_MODE        = 0,
  parameter int STARVE_LIMIT   = 4
) (
  input logic         clk,
  input logic         resetn,
  mem_arbiter_if.slave bus
);

  localparam logic [31:0] WORDS = mem_words(MEMORY_SIZE_KB);

  logic        i_gnt;
  logic        d_gnt;
  logic        any_gnt;
  logic [31:0] win_addr;
  logic        in_range;
  logic        do_write;
  owner_t      owner_q;
  logic        err_q;

  mem_arb_grant #(
    .RR_MODE      (RR_MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk    (clk),
    .resetn (resetn),
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .i_gnt  (i_gnt),
    .d_gnt  (d_gnt)
  );

  assign bus.i_gnt = i_gnt;
  assign bus.d_gnt = d_gnt;
  assign any_gnt   = i_gnt || d_gnt;
  assign win_addr  = d_gnt ? bus.d_addr : bus.i_addr;
  assign in_range  = (win_addr >> 2) < WORDS;
  assign do_write  = d_gnt && bus.d_we && in_range;

  // Out-of-range accesses are granted but never reach the memory.
  always_comb begin
    bus.mem_addr  = any_gnt ? (win_addr & ~32'h3) : 32'h0;
    bus.mem_rstrb = in_range && (i_gnt || (d_gnt && !bus.d_we));
    bus.mem_wmask = do_write ? bus.d_wmask : 4'b0000;
    bus.mem_wdata = do_write ? bus.d_wdata : 32'h0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= i_gnt ? OWN_I : (d_gnt ? OWN_D : OWN_NONE);
      err_q   <= any_gnt && !in_range;
    end
  end

  assign bus.i_rvalid = (owner_q == OWN_I);
  assign bus.d_rvalid = (owner_q == OWN_D);
  assign bus.i_err    = bus.i_rvalid && err_q;
  assign bus.d_err    = bus.d_rvalid && err_q;
  assign bus.i_rdata  = (bus.i_rvalid && !err_q) ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata  = (bus.d_rvalid && !err_q) ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority and a round-robin instance share the
// same directed stimulus and are checked every cycle against a rule-level model.
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int WORDS  = 2048;

  logic clk;
  logic resetn;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] rd0, rd1;
  logic [31:0] mem0 [WORDS];
  logic [31:0] mem1 [WORDS];

  int vec_cnt  = 0;
  int miscmp   = 0;

  // model state, per instance (0 = fixed priority, 1 = round robin)
  int          m_cnt    [2];
  logic        m_last_d [2];
  int          m_pend   [2];
  logic        m_perr   [2];
  logic        m_pwr    [2];
  logic [31:0] m_pdata  [2];
  logic [31:0] ref_mem  [2][WORDS];

  mem_arbiter_if bus0 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.MEMORY_SIZE_KB(8), .RR_MODE(0), .STARVE_LIMIT(STARVE)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0));
  mem_arbiter #(.MEMORY_SIZE_KB(8), .RR_MODE(1), .STARVE_LIMIT(STARVE)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1));

  assign bus0.i_req = i_req;   assign bus1.i_req = i_req;
  assign bus0.i_addr = i_addr; assign bus1.i_addr = i_addr;
  assign bus0.d_req = d_req;   assign bus1.d_req = d_req;
  assign bus0.d_we = d_we;     assign bus1.d_we = d_we;
  assign bus0.d_wmask = d_wmask; assign bus1.d_wmask = d_wmask;
  assign bus0.d_addr = d_addr; assign bus1.d_addr = d_addr;
  assign bus0.d_wdata = d_wdata; assign bus1.d_wdata = d_wdata;
  assign bus0.mem_rdata = rd0; assign bus1.mem_rdata = rd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pre(input int w);
    if (w == 4) return 32'h0010_0073;
    if (w == 8) return 32'h1122_3344;
    return (32'(w) * 32'h0001_0001) ^ 32'h5A5A_0000;
  endfunction

  // synchronous-read memories, reloaded while reset is held
  always @(posedge clk) begin
    if (!resetn) begin
      for (int w = 0; w < WORDS; w++) begin
        mem0[w] <= pre(w);
        mem1[w] <= pre(w);
      end
    end else begin
      if (bus0.mem_rstrb) rd0 <= mem0[bus0.mem_addr[12:2]];
      if (bus1.mem_rstrb) rd1 <= mem1[bus1.mem_addr[12:2]];
      for (int b = 0; b < 4; b++) begin
        if (bus0.mem_wmask[b]) mem0[bus0.mem_addr[12:2]][8*b +: 8] <= bus0.mem_wdata[8*b +: 8];
        if (bus1.mem_wmask[b]) mem1[bus1.mem_addr[12:2]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k,
                            input logic ig, input logic dg,
                            input logic iv, input logic ie, input logic [31:0] ird,
                            input logic dv, input logic de, input logic [31:0] drd,
                            input logic [31:0] ma, input logic rs,
                            input logic [3:0] wm, input logic [31:0] wd);
    logic wi, wdn, inr, rd, wr;
    logic [31:0] a;
    int w;
    string p;
    p = $sformatf("dut%0d", k);
    if (!resetn) begin
      chk({p, " rst i_rvalid"}, 32'(iv), 32'd0);
      chk({p, " rst d_rvalid"}, 32'(dv), 32'd0);
      chk({p, " rst errs"}, 32'({ie, de}), 32'd0);
      chk({p, " rst rstrb"}, 32'(rs), 32'd0);
      m_cnt[k] = 0; m_last_d[k] = 1'b1; m_pend[k] = 0;
      m_perr[k] = 1'b0; m_pwr[k] = 1'b0; m_pdata[k] = 32'h0;
      for (int j = 0; j < WORDS; j++) ref_mem[k][j] = pre(j);
      return;
    end
    if (i_req && d_req) wi = (k == 1) ? m_last_d[k] : (m_cnt[k] == STARVE);
    else                wi = i_req;
    wdn = d_req && !wi;
    chk({p, " i_gnt"}, 32'(ig), 32'(wi));
    chk({p, " d_gnt"}, 32'(dg), 32'(wdn));
    chk({p, " i_rvalid"}, 32'(iv), 32'(m_pend[k] == 1));
    chk({p, " d_rvalid"}, 32'(dv), 32'(m_pend[k] == 2));
    if (m_pend[k] == 1) begin
      chk({p, " i_err"}, 32'(ie), 32'(m_perr[k]));
      chk({p, " i_rdata"}, ird, m_pdata[k]);
    end
    if (m_pend[k] == 2) begin
      chk({p, " d_err"}, 32'(de), 32'(m_perr[k]));
      if (!m_pwr[k]) chk({p, " d_rdata"}, drd, m_pdata[k]);
    end
    a   = wi ? i_addr : d_addr;
    inr = (a >> 2) < 32'(WORDS);
    w   = inr ? int'(a >> 2) : 0;
    rd  = inr && (wi || (wdn && !d_we));
    wr  = inr && wdn && d_we;
    chk({p, " mem_rstrb"}, 32'(rs), 32'(rd));
    chk({p, " mem_wmask"}, 32'(wm), wr ? 32'(d_wmask) : 32'd0);
    if (wi || wdn) chk({p, " mem_addr"}, ma, a & ~32'h3);
    if (wr && d_wmask != 4'b0) chk({p, " mem_wdata"}, wd, d_wdata);
    m_pend[k]  = wi ? 1 : (wdn ? 2 : 0);
    m_perr[k]  = !inr;
    m_pwr[k]   = wdn && d_we;
    m_pdata[k] = inr ? ref_mem[k][w] : 32'h0;
    if (wr)
      for (int b = 0; b < 4; b++)
        if (d_wmask[b]) ref_mem[k][w][8*b +: 8] = d_wdata[8*b +: 8];
    if (i_req && !wi) m_cnt[k] = (m_cnt[k] < STARVE) ? m_cnt[k] + 1 : STARVE;
    else              m_cnt[k] = 0;
    if (wdn)     m_last_d[k] = 1'b1;
    else if (wi) m_last_d[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    model_step(0, bus0.i_gnt, bus0.d_gnt, bus0.i_rvalid, bus0.i_err, bus0.i_rdata,
               bus0.d_rvalid, bus0.d_err, bus0.d_rdata,
               bus0.mem_addr, bus0.mem_rstrb, bus0.mem_wmask, bus0.mem_wdata);
    model_step(1, bus1.i_gnt, bus1.d_gnt, bus1.i_rvalid, bus1.i_err, bus1.i_rdata,
               bus1.d_rvalid, bus1.d_err, bus1.d_rdata,
               bus1.mem_addr, bus1.mem_rstrb, bus1.mem_wmask, bus1.mem_wdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wmask = 4'b0;
  endtask

  logic [5:0] seq0, seq1;

  initial begin
    resetn = 1'b0;
    idle();
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) step();
    @(negedge clk);
    chk("reset d_rvalid", 32'(bus0.d_rvalid), 32'd0);
    step();
    resetn = 1'b1;

    // single instruction read of word 4
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    chk("single i_gnt", 32'(bus0.i_gnt), 32'd1);
    chk("single mem_addr", bus0.mem_addr, 32'h10);
    step(); idle();
    @(negedge clk);
    chk("single i_rvalid", 32'(bus0.i_rvalid), 32'd1);
    chk("single i_rdata", bus0.i_rdata, 32'h0010_0073);
    chk("single i_err", 32'(bus0.i_err), 32'd0);

    // continuous conflict, then a second burst after one idle cycle
    step();
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h14;
    seq0 = '0; seq1 = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seq0 = {seq0[4:0], bus0.d_gnt};
      seq1 = {seq1[4:0], bus1.d_gnt};
      step();
    end
    chk("prio d_gnt seq", 32'(seq0), 32'(6'b111101));
    chk("rr d_gnt seq", 32'(seq1), 32'(6'b101010));
    idle(); step();
    i_req = 1'b1; d_req = 1'b1;
    seq0 = '0; seq1 = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      seq0 = {seq0[4:0], bus0.d_gnt};
      seq1 = {seq1[4:0], bus1.d_gnt};
      step();
    end
    chk("prio d_gnt seq2", 32'(seq0), 32'(5'b11110));
    chk("rr d_gnt seq2", 32'(seq1), 32'(5'b10101));
    idle(); step();

    // partial write, then read back the word
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0011; d_addr = 32'h22; d_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    chk("write mem_addr", bus0.mem_addr, 32'h20);
    chk("write mem_wmask", 32'(bus0.mem_wmask), 32'h3);
    step(); idle();
    @(negedge clk);
    chk("write d_rvalid", 32'(bus0.d_rvalid), 32'd1);
    step();
    d_req = 1'b1; d_addr = 32'h20;
    step(); idle();
    @(negedge clk);
    chk("readback d_rdata", bus0.d_rdata, 32'h1122_CCDD);

    // empty-mask write completes without touching memory
    step();
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0000; d_addr = 32'h20; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mask0 mem_wmask", 32'(bus0.mem_wmask), 32'd0);
    step(); idle();
    @(negedge clk);
    chk("mask0 d_rvalid", 32'(bus1.d_rvalid), 32'd1);
    step();
    d_req = 1'b1; d_addr = 32'h20;
    step(); idle();
    @(negedge clk);
    chk("mask0 readback", bus1.d_rdata, 32'h1122_CCDD);

    // out of range and the last legal word
    step();
    d_req = 1'b1; d_addr = 32'h2000;
    @(negedge clk);
    chk("oob mem_rstrb", 32'(bus0.mem_rstrb), 32'd0);
    step(); idle();
    @(negedge clk);
    chk("oob d_err", 32'(bus0.d_err), 32'd1);
    chk("oob d_rdata", bus0.d_rdata, 32'h0);
    step();
    i_req = 1'b1; i_addr = 32'hFFFF_FFF0; d_req = 1'b1; d_addr = 32'h1FFC;
    repeat (3) step();
    idle(); step();

    // back-to-back fetches, then back-to-back data accesses
    for (int c = 0; c < 4; c++) begin
      i_req = 1'b1; i_addr = 32'h40 + 32'(4 * c);
      step();
    end
    idle();
    for (int c = 0; c < 4; c++) begin
      d_req = 1'b1; d_we = c[0]; d_wmask = 4'b1100; d_addr = 32'h80;
      d_wdata = 32'h1234_0000 + 32'(c);
      step();
    end
    idle(); step();

    // reset in the response cycle
    i_req = 1'b1; i_addr = 32'h10;
    step(); idle();
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst i_rvalid", 32'(bus0.i_rvalid), 32'd0);
    step(); step();
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post-rst rvalid", 32'({bus0.i_rvalid, bus0.d_rvalid, bus1.i_rvalid, bus1.d_rvalid}), 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
